// File: rtl/ysyx_25050136_axi4_master_pkg.sv
// Shared AXI4 encodings, FSM state type and alignment helper for the
// single-outstanding AXI4 manager bridge.
package ysyx_25050136_axi4_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RESP
  } state_t;

  // Sizes above a word use the word mask, so they can only fault on low bits.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    logic [1:0] mask;
    case (size)
      3'd0:    mask = 2'b00;
      3'd1:    mask = 2'b01;
      default: mask = 2'b11;
    endcase
    return |(addr_lo & mask);
  endfunction

endpackage

// File: rtl/ysyx_25050136_axi4_master.sv
// Core request/response port to AXI4 bridge: one single-beat read or write
// in flight at a time, all AXI outputs driven from registers.
module ysyx_25050136_axi4_master
  import ysyx_25050136_axi4_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [2:0]                req_size,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [3:0]                m_awid,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wlast,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  input  logic [3:0]                m_bid,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [3:0]                m_arid,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic [3:0]                m_rid,
  input  logic                      m_rlast
);

  state_t                    r_state;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [2:0]                r_size;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_wstrb;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic                      r_bready;
  logic                      r_arvalid;
  logic                      r_rready;
  logic                      r_rsp_valid;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata;
  logic                      r_rsp_err;

  logic                      w_aw_fire;
  logic                      w_w_fire;
  logic                      w_aw_all;
  logic                      w_w_all;

  assign w_aw_fire = r_awvalid & m_awready;
  assign w_w_fire  = r_wvalid & m_wready;
  assign w_aw_all  = r_aw_done | w_aw_fire;
  assign w_w_all   = r_w_done | w_w_fire;

  // Gated by reset so the port is closed during reset and open on the first cycle after.
  assign req_ready = (r_state == S_IDLE) & ~reset;

  assign m_awvalid = r_awvalid;
  assign m_awaddr  = r_addr;
  assign m_awid    = AXI_ID;
  assign m_awlen   = '0;
  assign m_awsize  = r_size;
  assign m_awburst = BURST_INCR;
  assign m_wvalid  = r_wvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_wlast   = 1'b1;
  assign m_bready  = r_bready;
  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_addr;
  assign m_arid    = AXI_ID;
  assign m_arlen   = '0;
  assign m_arsize  = r_size;
  assign m_arburst = BURST_INCR;
  assign m_rready  = r_rready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_size      <= req_size;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            if (misaligned(req_addr[1:0], req_size)) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (req_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= m_rdata;
            r_rsp_err   <= (m_rresp != RESP_OKAY) | (m_rid != AXI_ID) | ~m_rlast;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_WR_REQ: begin
          // AW and W retire independently; the phase ends once both have fired.
          if (w_aw_fire) r_awvalid <= 1'b0;
          if (w_w_fire)  r_wvalid  <= 1'b0;
          r_aw_done <= w_aw_all;
          r_w_done  <= w_w_all;
          if (w_aw_all && w_w_all) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_err   <= (m_bresp != RESP_OKAY) | (m_bid != AXI_ID);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25050136_axi4_master.sv
// Self-checking bench: behavioural AXI subordinate with programmable waits and
// response codes, plus a word-memory reference model of the expected responses.
module tb_ysyx_25050136_axi4_master;
  import ysyx_25050136_axi4_master_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_awid, m_wstrb, m_bid, m_arid, m_rid;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_bresp, m_arburst, m_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;

  ysyx_25050136_axi4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rlast(m_rlast)
  );

  int checks = 0, passed = 0, viol = 0;

  // Subordinate knobs
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [1:0] k_rresp = RESP_OKAY, k_bresp = RESP_OKAY;
  logic [3:0] k_rid = 4'd0, k_bid = 4'd0;
  logic       k_rlast = 1'b1;

  // Subordinate state shared with the monitor
  logic [31:0] sub_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic rd_pend, r_fire_seen, b_fire_seen, wr_aw_got, wr_w_got;
  logic [31:0] rd_addr, wr_awaddr, wr_wdata;
  logic [3:0]  wr_wstrb;

  // Per-transaction monitor record
  int ar_fires, aw_fires, w_fires, valid_cycles;
  logic [31:0] mon_araddr, mon_awaddr, mon_wdata;
  logic [2:0]  mon_arsize, mon_awsize;
  logic [7:0]  mon_arlen, mon_awlen;
  logic [1:0]  mon_arburst, mon_awburst;
  logic [3:0]  mon_arid, mon_awid, mon_wstrb;
  logic        mon_wlast;

  function automatic logic [31:0] sub_rd(input logic [29:0] k);
    return sub_mem.exists(k) ? sub_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic sub_reset();
    m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
    m_rdata = '0; m_rresp = '0; m_rid = '0; m_rlast = 0; m_bresp = '0; m_bid = '0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    rd_pend = 0; r_fire_seen = 0; b_fire_seen = 0; wr_aw_got = 0; wr_w_got = 0;
  endtask

  // Subordinate: updates its outputs just after each rising edge
  initial begin
    logic [31:0] cur;
    sub_reset();
    forever begin
      @(posedge clk); #1;
      if (reset) sub_reset();
      else begin
        m_arready = m_arvalid && (ar_cnt >= ar_wait); ar_cnt = m_arvalid ? ar_cnt + 1 : 0;
        m_awready = m_awvalid && (aw_cnt >= aw_wait); aw_cnt = m_awvalid ? aw_cnt + 1 : 0;
        m_wready  = m_wvalid  && (w_cnt  >= w_wait);  w_cnt  = m_wvalid  ? w_cnt + 1  : 0;
        if (r_fire_seen) begin m_rvalid = 0; r_fire_seen = 0; end
        if (rd_pend && !m_rvalid) begin
          if (r_cnt >= r_wait) begin
            m_rvalid = 1; m_rdata = sub_rd(rd_addr[31:2]); m_rresp = k_rresp;
            m_rid = k_rid; m_rlast = k_rlast; rd_pend = 0;
          end else r_cnt++;
        end
        if (b_fire_seen) begin m_bvalid = 0; b_fire_seen = 0; end
        if (wr_aw_got && wr_w_got && !m_bvalid) begin
          if (b_cnt >= b_wait) begin
            cur = sub_rd(wr_awaddr[31:2]);
            for (int i = 0; i < 4; i++) if (wr_wstrb[i]) cur[8*i +: 8] = wr_wdata[8*i +: 8];
            sub_mem[wr_awaddr[31:2]] = cur;
            m_bvalid = 1; m_bresp = k_bresp; m_bid = k_bid;
            wr_aw_got = 0; wr_w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
      end
    end
  end

  // Monitor: handshakes are stable mid-cycle, so fires are decided at the falling edge
  initial begin
    logic p_rst, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr, p_err;
    logic [31:0] p_araddr, p_awaddr, p_wdata, p_rdata;
    logic [2:0] p_arsize, p_awsize;
    logic [3:0] p_wstrb;
    p_rst = 1; {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr, p_err} = '0;
    forever begin
      @(negedge clk);
      if (!reset && !p_rst) begin
        if (m_bready && (aw_fires == 0 || w_fires == 0)) viol++;
        if (p_arv && !p_arr && (!m_arvalid || m_araddr !== p_araddr || m_arsize !== p_arsize)) viol++;
        if (p_awv && !p_awr && (!m_awvalid || m_awaddr !== p_awaddr || m_awsize !== p_awsize)) viol++;
        if (p_wv && !p_wr && (!m_wvalid || m_wdata !== p_wdata || m_wstrb !== p_wstrb)) viol++;
        if (p_rv && !p_rr && (!rsp_valid || rsp_rdata !== p_rdata || rsp_err !== p_err)) viol++;
      end
      if (!reset) begin
        if (m_arvalid || m_awvalid || m_wvalid) valid_cycles++;
        if (m_arvalid && m_arready) begin
          ar_fires++; mon_araddr = m_araddr; mon_arsize = m_arsize; mon_arlen = m_arlen;
          mon_arburst = m_arburst; mon_arid = m_arid;
          rd_pend = 1; rd_addr = m_araddr; r_cnt = 0;
        end
        if (m_rvalid && m_rready) r_fire_seen = 1;
        if (m_awvalid && m_awready) begin
          aw_fires++; mon_awaddr = m_awaddr; mon_awsize = m_awsize; mon_awlen = m_awlen;
          mon_awburst = m_awburst; mon_awid = m_awid; wr_aw_got = 1; wr_awaddr = m_awaddr;
        end
        if (m_wvalid && m_wready) begin
          w_fires++; mon_wdata = m_wdata; mon_wstrb = m_wstrb; mon_wlast = m_wlast;
          wr_w_got = 1; wr_wdata = m_wdata; wr_wstrb = m_wstrb;
        end
        if (m_bvalid && m_bready) b_fire_seen = 1;
      end
      p_rst = reset; p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr; p_arsize = m_arsize;
      p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr; p_awsize = m_awsize;
      p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
      p_rv = rsp_valid; p_rr = rsp_ready; p_rdata = rsp_rdata; p_err = rsp_err;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    sub_mem[a[31:2]] = v; ref_mem[a[31:2]] = v;
  endtask

  task automatic ok_knobs();
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    k_rresp = RESP_OKAY; k_bresp = RESP_OKAY; k_rid = 4'd0; k_bid = 4'd0; k_rlast = 1'b1;
  endtask

  // One request through the DUT, checked against the reference model
  task automatic run_txn(input string nm, input logic we, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input int hold);
    logic mis, exp_err;
    logic [31:0] exp_rdata, cur;
    int exp_lat, c, v0;
    mis = (addr % (32'd1 << size)) != 0;
    if (mis) begin
      exp_err = 1; exp_rdata = 0; exp_lat = 1;
    end else if (we) begin
      exp_err = (k_bresp != RESP_OKAY) || (k_bid != 4'd0);
      exp_rdata = 0;
      exp_lat = 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
      cur = ref_rd(addr[31:2]);
      for (int i = 0; i < 4; i++) if (wstrb[i]) cur[8*i +: 8] = wdata[8*i +: 8];
      ref_mem[addr[31:2]] = cur;
    end else begin
      exp_err = (k_rresp != RESP_OKAY) || (k_rid != 4'd0) || !k_rlast;
      exp_rdata = ref_rd(addr[31:2]);
      exp_lat = 3 + ar_wait + r_wait;
    end
    ar_fires = 0; aw_fires = 0; w_fires = 0; valid_cycles = 0; v0 = viol;
    req_valid = 1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata; req_wstrb = wstrb;
    c = 0;
    while (!req_ready && c < 20) begin step(); c++; end
    checks++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready: got %b want 1", nm, req_ready); else passed++;
    step();
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_size = 3'($urandom);
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    c = 1;
    while (!rsp_valid && c < 100) begin step(); c++; end
    checks++;
    if (c != exp_lat) $display("FAIL %s latency: got %0d want %0d", nm, c, exp_lat); else passed++;
    for (int h = 0; h < hold; h++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0)
        $display("FAIL %s hold: got valid=%b req_ready=%b want 1/0", nm, rsp_valid, req_ready);
      else passed++;
    end
    checks++;
    if (rsp_err !== exp_err) $display("FAIL %s rsp_err: got %b want %b", nm, rsp_err, exp_err); else passed++;
    checks++;
    if (rsp_rdata !== exp_rdata) $display("FAIL %s rsp_rdata: got %h want %h", nm, rsp_rdata, exp_rdata); else passed++;
    rsp_ready = 1; step(); rsp_ready = 0;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10)
      $display("FAIL %s after_rsp: got req_ready=%b rsp_valid=%b want 1/0", nm, req_ready, rsp_valid);
    else passed++;
    checks++;
    if (mis) begin
      if (valid_cycles != 0) $display("FAIL %s bus_activity: got %0d want 0", nm, valid_cycles); else passed++;
    end else if (we) begin
      if ({ar_fires, aw_fires, w_fires} != {32'd0, 32'd1, 32'd1})
        $display("FAIL %s fires: got ar=%0d aw=%0d w=%0d want 0/1/1", nm, ar_fires, aw_fires, w_fires);
      else passed++;
      checks++;
      if ({mon_awaddr, mon_awsize, mon_awlen, mon_awburst, mon_awid, mon_wdata, mon_wstrb, mon_wlast} !==
          {addr, size, 8'd0, 2'b01, 4'd0, wdata, wstrb, 1'b1})
        $display("FAIL %s aw_w_fields: got %h %h %h %h %h %h %h %b want %h %h 00 1 0 %h %h 1", nm,
                 mon_awaddr, mon_awsize, mon_awlen, mon_awburst, mon_awid, mon_wdata, mon_wstrb, mon_wlast,
                 addr, size, wdata, wstrb);
      else passed++;
    end else begin
      if ({ar_fires, aw_fires, w_fires} != {32'd1, 32'd0, 32'd0})
        $display("FAIL %s fires: got ar=%0d aw=%0d w=%0d want 1/0/0", nm, ar_fires, aw_fires, w_fires);
      else passed++;
      checks++;
      if ({mon_araddr, mon_arsize, mon_arlen, mon_arburst, mon_arid} !== {addr, size, 8'd0, 2'b01, 4'd0})
        $display("FAIL %s ar_fields: got %h %h %h %h %h want %h %h 00 1 0", nm,
                 mon_araddr, mon_arsize, mon_arlen, mon_arburst, mon_arid, addr, size);
      else passed++;
    end
    checks++;
    if (viol != v0) $display("FAIL %s protocol: got %0d violations want 0", nm, viol - v0); else passed++;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({req_ready, m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready, rsp_valid, rsp_err} !== 8'h00)
      $display("FAIL reset_ctl: got %b want 00000000",
               {req_ready, m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready, rsp_valid, rsp_err});
    else passed++;
    checks++;
    if ({rsp_rdata, m_araddr, m_awaddr, m_wdata, m_arid, m_awid} !== '0)
      $display("FAIL reset_data: got %h %h %h %h want 0", rsp_rdata, m_araddr, m_awaddr, m_wdata);
    else passed++;
    reset = 0;
    step();
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release req_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_read_basic();
    ok_knobs();
    preload(32'h8000_0000, 32'hDEAD_BEEF);
    run_txn("rd_basic", 0, 32'h8000_0000, 3'd2, 32'h0, 4'h0, 0);
  endtask

  task automatic test_write_skew();
    ok_knobs(); aw_wait = 0; w_wait = 3;
    run_txn("wr_skew_aw_first", 1, 32'h8000_0004, 3'd2, 32'h1234_5678, 4'hF, 0);
    ok_knobs();
    run_txn("rd_back_skew", 0, 32'h8000_0004, 3'd2, 32'h0, 4'h0, 0);
  endtask

  task automatic test_byte_slverr();
    ok_knobs(); aw_wait = 2; w_wait = 0; k_bresp = RESP_SLVERR;
    run_txn("wr_byte_slverr", 1, 32'h8000_0003, 3'd0, 32'hA1B2_C3D4, 4'b1000, 0);
    ok_knobs();
    run_txn("rd_back_byte", 0, 32'h8000_0000, 3'd2, 32'h0, 4'h0, 0);
  endtask

  task automatic test_read_errors();
    ok_knobs(); k_rid = 4'd5;
    run_txn("rd_bad_id", 0, 32'h8000_0000, 3'd2, 32'h0, 4'h0, 0);
    ok_knobs(); k_rlast = 1'b0;
    run_txn("rd_no_last", 0, 32'h8000_0004, 3'd2, 32'h0, 4'h0, 0);
    ok_knobs(); k_rresp = RESP_DECERR; ar_wait = 2; r_wait = 1;
    run_txn("rd_decerr", 0, 32'h8000_0002, 3'd1, 32'h0, 4'h0, 0);
    ok_knobs(); k_bid = 4'd3;
    run_txn("wr_bad_bid", 1, 32'h8000_0008, 3'd2, 32'h0BAD_0B1D, 4'h3, 0);
    ok_knobs();
  endtask

  task automatic test_misaligned();
    ok_knobs();
    run_txn("rd_misaligned", 0, 32'h8000_0002, 3'd2, 32'h0, 4'h0, 0);
    run_txn("wr_misaligned", 1, 32'h8000_0001, 3'd1, 32'hFFFF_FFFF, 4'hF, 0);
  endtask

  task automatic test_back_to_back();
    ok_knobs();
    run_txn("rd_hold", 0, 32'h8000_0004, 3'd2, 32'h0, 4'h0, 4);
    run_txn("b2b_write", 1, 32'h8000_000C, 3'd2, 32'hCAFE_F00D, 4'hF, 1);
  endtask

  task automatic test_reset_mid();
    int c;
    ok_knobs(); r_wait = 1000;
    req_valid = 1; req_we = 0; req_addr = 32'h8000_0000; req_size = 3'd2;
    step(); req_valid = 0;
    c = 0;
    while (!m_rready && c < 20) begin step(); c++; end
    checks++;
    if (m_rready !== 1'b1) $display("FAIL reset_mid reach_rd_data: got %b want 1", m_rready); else passed++;
    reset = 1;
    step();
    checks++;
    if ({m_arvalid, m_rready, rsp_valid, req_ready, m_awvalid, m_wvalid, m_bready} !== 7'b0)
      $display("FAIL reset_mid outputs: got %b want 0000000",
               {m_arvalid, m_rready, rsp_valid, req_ready, m_awvalid, m_wvalid, m_bready});
    else passed++;
    step();
    reset = 0; r_wait = 0;
    step();
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10)
      $display("FAIL reset_mid release: got req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
    else passed++;
    run_txn("rd_after_reset", 0, 32'h8000_0000, 3'd2, 32'h0, 4'h0, 0);
  endtask

  task automatic test_random();
    logic we;
    logic [31:0] a;
    logic [2:0] sz;
    for (int n = 0; n < 40; n++) begin
      ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 2);
      k_rresp = ($urandom_range(0, 7) == 0) ? RESP_SLVERR : RESP_OKAY;
      k_bresp = ($urandom_range(0, 7) == 0) ? RESP_DECERR : RESP_OKAY;
      k_rid   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      k_bid   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      k_rlast = ($urandom_range(0, 9) != 0);
      we = 1'($urandom);
      a  = 32'h8000_0000 + $urandom_range(0, 63);
      sz = 3'($urandom_range(0, 2));
      run_txn($sformatf("rand%0d", n), we, a, sz, $urandom, 4'($urandom), $urandom_range(0, 2));
    end
    ok_knobs();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_skew();
    test_byte_slverr();
    test_read_errors();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
